// File: rtl/radar_sim_pkg.sv
// radar_sim_pkg
// Shared definitions for the radar simulator run controller:
//   STATE_W / MISS_W  widths of the published state and miss counter
//   STATE_*           encodings of the controller states as seen on STATE
//   state_t           FSM state type built from those encodings
//   miss_inc()        saturating increment for the miss counter
package radar_sim_pkg;

  localparam int STATE_W = 3;
  localparam int MISS_W  = 8;

  localparam logic [STATE_W-1:0] STATE_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] STATE_WAIT_CAL = 3'd1;
  localparam logic [STATE_W-1:0] STATE_ARM      = 3'd2;
  localparam logic [STATE_W-1:0] STATE_RUN      = 3'd3;
  localparam logic [STATE_W-1:0] STATE_FAULT    = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = STATE_IDLE,
    ST_WAIT_CAL = STATE_WAIT_CAL,
    ST_ARM      = STATE_ARM,
    ST_RUN      = STATE_RUN,
    ST_FAULT    = STATE_FAULT
  } state_t;

  // Miss counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [MISS_W-1:0] miss_inc(input logic [MISS_W-1:0] m);
    return (m == {MISS_W{1'b1}}) ? m : m + MISS_W'(1);
  endfunction

endpackage

// File: rtl/radar_edge_sync.sv
// radar_edge_sync
// Synchronizes one asynchronous radar input into the US_CLK domain and
// emits a one-cycle pulse on each rising edge.
//   US_CLK  1 MHz clock
//   RST_N   synchronous active-low reset (clears the synchronizer)
//   D       raw asynchronous input
//   PULSE   one-cycle rising-edge pulse, valid SYNC_STAGES cycles after D rises
module radar_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic US_CLK,
  input  logic RST_N,
  input  logic D,
  output logic PULSE
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge US_CLK) begin
    if (!RST_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], D};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Built only from flops, so the consumer registers it on the next edge.
  assign PULSE = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/radar_sim_ctrl.sv
// radar_sim_ctrl
// Run controller for the radar simulator. Gates SIM_EN so the simulator
// output starts on a revolution boundary after calibration, publishes the
// azimuth index (ACP rises since ARP) and trigger index (TRIG rises since
// ACP), and latches FAULT when MAX_MISS consecutive revolutions carry the
// wrong number of ACP edges.
// Ports:
//   US_CLK, RST_N            1 MHz clock, synchronous active-low reset
//   ARP, ACP, TRIG           raw asynchronous antenna inputs
//   CALIBRATED, ACP_CNT, ARP_US  statistics results
//   EN, CLR_FAULT            software run request / one-cycle fault clear
//   SIM_EN, REV_START        output enable, one pulse per accepted ARP
//   AZ_IDX, TRIG_IDX         saturating indices
//   STATE, FAULT, MISS_CNT   controller state, sticky fault, miss count
// Build option:
//   RADAR_SIM_CTRL_WATCHDOG_EN  adds a revolution watchdog in RUN that
//   faults once the time since the last ARP exceeds 1.5 * ARP_US
//   (ARP_US == 0 disables it).
// All outputs are registered; the state register drives STATE directly.
module radar_sim_ctrl
  import radar_sim_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MISS    = 3
) (
  input  logic                  US_CLK,
  input  logic                  RST_N,
  input  logic                  ARP,
  input  logic                  ACP,
  input  logic                  TRIG,
  input  logic                  CALIBRATED,
  input  logic [DATA_WIDTH-1:0] ACP_CNT,
  input  logic [DATA_WIDTH-1:0] ARP_US,
  input  logic                  EN,
  input  logic                  CLR_FAULT,
  output logic                  SIM_EN,
  output logic                  REV_START,
  output logic [DATA_WIDTH-1:0] AZ_IDX,
  output logic [DATA_WIDTH-1:0] TRIG_IDX,
  output logic [STATE_W-1:0]    STATE,
  output logic                  FAULT,
  output logic [MISS_W-1:0]     MISS_CNT
);

  localparam logic [MISS_W-1:0] MAX_MISS_V = MISS_W'(MAX_MISS);

  logic arp_e, acp_e, trig_e;

  radar_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_arp_sync (
    .US_CLK(US_CLK), .RST_N(RST_N), .D(ARP),  .PULSE(arp_e)
  );
  radar_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_acp_sync (
    .US_CLK(US_CLK), .RST_N(RST_N), .D(ACP),  .PULSE(acp_e)
  );
  radar_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
    .US_CLK(US_CLK), .RST_N(RST_N), .D(TRIG), .PULSE(trig_e)
  );

  state_t              state_q;
  logic [MISS_W-1:0]   miss_next;
  logic                miss_fault;
  logic                wd_fault;

  assign STATE = state_q;

  // Revolution verdict uses the pre-edge azimuth count, so an ACP edge that
  // coincides with ARP is not counted in the closing revolution.
  assign miss_next  = (AZ_IDX == ACP_CNT) ? '0 : miss_inc(MISS_CNT);
  assign miss_fault = arp_e && (miss_next >= MAX_MISS_V);

`ifdef RADAR_SIM_CTRL_WATCHDOG_EN
  logic [DATA_WIDTH-1:0] wd_cnt;
  logic [DATA_WIDTH:0]   wd_limit;

  // One extra bit keeps 1.5 * ARP_US from overflowing.
  assign wd_limit = {1'b0, ARP_US} + {2'b00, ARP_US[DATA_WIDTH-1:1]};
  assign wd_fault = (state_q == ST_RUN) && (ARP_US != '0) &&
                    ({1'b0, wd_cnt} > wd_limit);

  always_ff @(posedge US_CLK) begin
    if (!RST_N || state_q != ST_RUN || arp_e) begin
      wd_cnt <= '0;
    end else if (wd_cnt != {DATA_WIDTH{1'b1}}) begin
      wd_cnt <= wd_cnt + DATA_WIDTH'(1);
    end
  end
`else
  logic unused_arp_us;
  assign unused_arp_us = ^ARP_US;
  assign wd_fault      = 1'b0;
`endif

  always_ff @(posedge US_CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      SIM_EN    <= 1'b0;
      REV_START <= 1'b0;
      AZ_IDX    <= '0;
      TRIG_IDX  <= '0;
      FAULT     <= 1'b0;
      MISS_CNT  <= '0;
    end else begin
      REV_START <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          SIM_EN   <= 1'b0;
          AZ_IDX   <= '0;
          TRIG_IDX <= '0;
          if (EN) state_q <= ST_WAIT_CAL;
        end
        ST_WAIT_CAL: begin
          SIM_EN <= 1'b0;
          if (!EN) begin
            state_q  <= ST_IDLE;
            AZ_IDX   <= '0;
            TRIG_IDX <= '0;
          end else if (CALIBRATED) begin
            state_q <= ST_ARM;
          end
        end
        ST_ARM: begin
          SIM_EN <= 1'b0;
          if (!EN) begin
            state_q  <= ST_IDLE;
            AZ_IDX   <= '0;
            TRIG_IDX <= '0;
          end else if (!CALIBRATED) begin
            state_q <= ST_WAIT_CAL;
          end else if (arp_e) begin
            // First revolution boundary: output starts with REV_START.
            state_q   <= ST_RUN;
            SIM_EN    <= 1'b1;
            REV_START <= 1'b1;
            AZ_IDX    <= '0;
            TRIG_IDX  <= '0;
            MISS_CNT  <= '0;
          end
        end
        ST_RUN: begin
          if (miss_fault || wd_fault) begin
            state_q <= ST_FAULT;
            SIM_EN  <= 1'b0;
            FAULT   <= 1'b1;
            if (arp_e) MISS_CNT <= miss_next;
          end else if (!EN) begin
            state_q  <= ST_IDLE;
            SIM_EN   <= 1'b0;
            AZ_IDX   <= '0;
            TRIG_IDX <= '0;
          end else if (!CALIBRATED) begin
            state_q <= ST_WAIT_CAL;
            SIM_EN  <= 1'b0;
          end else if (arp_e) begin
            MISS_CNT  <= miss_next;
            REV_START <= 1'b1;
            AZ_IDX    <= '0;
            TRIG_IDX  <= '0;
          end else if (acp_e) begin
            if (AZ_IDX != {DATA_WIDTH{1'b1}}) AZ_IDX <= AZ_IDX + DATA_WIDTH'(1);
            // A TRIG edge in the same cycle is the first of the new ACP slot.
            TRIG_IDX <= trig_e ? DATA_WIDTH'(1) : '0;
          end else if (trig_e) begin
            if (TRIG_IDX != {DATA_WIDTH{1'b1}}) TRIG_IDX <= TRIG_IDX + DATA_WIDTH'(1);
          end
        end
        ST_FAULT: begin
          SIM_EN <= 1'b0;
          FAULT  <= 1'b1;
          if (CLR_FAULT) begin
            state_q  <= ST_IDLE;
            FAULT    <= 1'b0;
            MISS_CNT <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          SIM_EN  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radar_sim_ctrl.sv
// tb_radar_sim_ctrl
// Self-checking bench for radar_sim_ctrl with ACP_CNT=4 revolutions.
// Expected values are pushed to exp_q before stimulus and popped when the
// outputs are sampled (#1 after the rising edge).
module tb_radar_sim_ctrl;

  localparam int DW = 32;

  // ---------------- clock / reset / DUT ----------------
  logic          US_CLK = 1'b0;
  logic          RST_N, ARP, ACP, TRIG, CALIBRATED, EN, CLR_FAULT;
  logic [DW-1:0] ACP_CNT, ARP_US;
  logic          SIM_EN, REV_START, FAULT;
  logic [DW-1:0] AZ_IDX, TRIG_IDX;
  logic [2:0]    STATE;
  logic [7:0]    MISS_CNT;

  always #5 US_CLK = ~US_CLK;

  radar_sim_ctrl #(.DATA_WIDTH(DW), .SYNC_STAGES(2), .MAX_MISS(3)) dut (
    .US_CLK(US_CLK), .RST_N(RST_N), .ARP(ARP), .ACP(ACP), .TRIG(TRIG),
    .CALIBRATED(CALIBRATED), .ACP_CNT(ACP_CNT), .ARP_US(ARP_US),
    .EN(EN), .CLR_FAULT(CLR_FAULT), .SIM_EN(SIM_EN), .REV_START(REV_START),
    .AZ_IDX(AZ_IDX), .TRIG_IDX(TRIG_IDX), .STATE(STATE), .FAULT(FAULT),
    .MISS_CNT(MISS_CNT)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not reach the summary");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  int            rev_cnt  = 0;
  logic [DW-1:0] exp_q[$];

  always @(negedge US_CLK) if (REV_START === 1'b1) rev_cnt++;

  task automatic push(input logic [DW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act);
    logic [DW-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: got %0d, no expected value queued", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, e);
      end
    end
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    push(exp);
    check(name, act);
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge US_CLK);
      #1;
    end
  endtask

  // High 2 cycles, low 3: long enough to pass the synchronizer and settle.
  task automatic pulse_in(input bit a, input bit c, input bit t);
    ARP = a; ACP = c; TRIG = t;
    tick(2);
    ARP = 1'b0; ACP = 1'b0; TRIG = 1'b0;
    tick(3);
  endtask

  task automatic acps(input int n);
    for (int k = 0; k < n; k++) pulse_in(1'b0, 1'b1, 1'b0);
  endtask

  task automatic trigs(input int n);
    for (int k = 0; k < n; k++) pulse_in(1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- revolution table ----------------
  typedef struct {
    int n_acp;     // ACP edges in the revolution
    int n_trig;    // TRIG edges after the last ACP
    int exp_miss;  // MISS_CNT after the closing ARP
    int exp_state; // STATE after the closing ARP
    bit exp_run;   // still running after the closing ARP
  } row_t;

  row_t rows[8];
  int   r0;

  initial begin
    rows[0] = '{4, 2, 0, 3, 1'b1};
    rows[1] = '{4, 0, 0, 3, 1'b1};
    rows[2] = '{3, 1, 1, 3, 1'b1};
    rows[3] = '{5, 3, 2, 3, 1'b1};
    rows[4] = '{4, 1, 0, 3, 1'b1};
    rows[5] = '{3, 0, 1, 3, 1'b1};
    rows[6] = '{2, 2, 2, 3, 1'b1};
    rows[7] = '{3, 4, 3, 4, 1'b0};

    RST_N = 1'b0; ARP = 1'b0; ACP = 1'b0; TRIG = 1'b0;
    CALIBRATED = 1'b0; EN = 1'b0; CLR_FAULT = 1'b0;
    ACP_CNT = DW'(4); ARP_US = '0;
    tick(3);
    chk("reset_state",     DW'(STATE), 0);
    chk("reset_sim_en",    DW'(SIM_EN), 0);
    chk("reset_rev_start", DW'(REV_START), 0);
    chk("reset_az",        AZ_IDX, 0);
    chk("reset_trig",      TRIG_IDX, 0);
    chk("reset_fault",     DW'(FAULT), 0);
    chk("reset_miss",      DW'(MISS_CNT), 0);
    RST_N = 1'b1;
    tick(1);
    chk("idle_hold", DW'(STATE), 0);

    // IDLE -> WAIT_CAL -> ARM
    EN = 1'b1;
    tick(1);
    chk("en_to_wait_cal", DW'(STATE), 1);
    tick(2);
    chk("wait_cal_hold", DW'(STATE), 1);
    CALIBRATED = 1'b1;
    tick(1);
    chk("cal_to_arm", DW'(STATE), 2);
    chk("arm_sim_en", DW'(SIM_EN), 0);
    pulse_in(1'b0, 1'b1, 1'b0);
    chk("arm_ignores_acp", AZ_IDX, 0);
    chk("arm_stays", DW'(STATE), 2);

    // ARP latency: SYNC_STAGES+1 edges to RUN, SIM_EN with REV_START
    ARP = 1'b1;
    tick(2);
    chk("arp_latency_early", DW'(STATE), 2);
    tick(1);
    chk("arp_to_run",       DW'(STATE), 3);
    chk("run_sim_en",       DW'(SIM_EN), 1);
    chk("first_rev_start",  DW'(REV_START), 1);
    tick(1);
    chk("rev_start_1cycle", DW'(REV_START), 0);
    ARP = 1'b0;
    tick(3);

    // Table of revolutions: matches, misses, reset of the run, then FAULT
    for (int i = 0; i < 8; i++) begin
      push(DW'(rows[i].n_acp));
      push(DW'(rows[i].n_trig));
      acps(rows[i].n_acp);
      trigs(rows[i].n_trig);
      check("az_before_arp", AZ_IDX);
      check("trig_before_arp", TRIG_IDX);
      r0 = rev_cnt;
      push(DW'(rows[i].exp_miss));
      push(DW'(rows[i].exp_state));
      push(DW'(rows[i].exp_run));
      push(DW'(rows[i].exp_run ? r0 + 1 : r0));
      push(DW'(!rows[i].exp_run));
      pulse_in(1'b1, 1'b0, 1'b0);
      check("rev_miss", DW'(MISS_CNT));
      check("rev_state", DW'(STATE));
      check("rev_sim_en", DW'(SIM_EN));
      check("rev_start_count", DW'(rev_cnt));
      check("rev_fault", DW'(FAULT));
      if (rows[i].exp_run) chk("az_after_arp", AZ_IDX, 0);
    end

    // FAULT ignores EN; CLR_FAULT returns to IDLE and re-arms
    EN = 1'b0;
    tick(2);
    chk("fault_ignores_en0", DW'(STATE), 4);
    chk("fault_sim_en", DW'(SIM_EN), 0);
    EN = 1'b1;
    tick(2);
    chk("fault_ignores_en1", DW'(STATE), 4);
    CLR_FAULT = 1'b1;
    tick(1);
    CLR_FAULT = 1'b0;
    chk("clr_to_idle",   DW'(STATE), 0);
    chk("clr_fault_bit", DW'(FAULT), 0);
    chk("clr_miss",      DW'(MISS_CNT), 0);
    tick(2);
    chk("rearm", DW'(STATE), 2);
    pulse_in(1'b1, 1'b0, 1'b0);
    chk("rerun", DW'(STATE), 3);

    // ACP latency in RUN
    ACP = 1'b1;
    tick(2);
    chk("acp_latency_early", AZ_IDX, 0);
    tick(1);
    chk("acp_latency", AZ_IDX, 1);
    ACP = 1'b0;
    tick(3);

    // Coincident ACP+TRIG, then coincident ARP+ACP
    trigs(2);
    chk("trig_count", TRIG_IDX, 2);
    pulse_in(1'b0, 1'b1, 1'b1);
    chk("acp_trig_az",   AZ_IDX, 2);
    chk("acp_trig_trig", TRIG_IDX, 1);
    acps(2);
    pulse_in(1'b1, 1'b1, 1'b0);
    chk("arp_acp_az",    AZ_IDX, 0);
    chk("arp_acp_miss",  DW'(MISS_CNT), 0);
    chk("arp_acp_state", DW'(STATE), 3);
    acps(4);
    pulse_in(1'b1, 1'b0, 1'b0);
    chk("after_coincide_miss", DW'(MISS_CNT), 0);

    // CALIBRATED drop mid-RUN
    CALIBRATED = 1'b0;
    tick(1);
    chk("cal_drop_state",  DW'(STATE), 1);
    chk("cal_drop_sim_en", DW'(SIM_EN), 0);
    CALIBRATED = 1'b1;
    tick(1);
    chk("cal_back_arm", DW'(STATE), 2);
    tick(6);
    chk("arm_waits_arp", DW'(SIM_EN), 0);
    pulse_in(1'b1, 1'b0, 1'b0);
    chk("cal_rerun", DW'(SIM_EN), 1);

    // EN=0 mid-RUN clears indices
    acps(1);
    EN = 1'b0;
    tick(1);
    chk("en0_state", DW'(STATE), 0);
    chk("en0_az",    AZ_IDX, 0);
    chk("en0_sim",   DW'(SIM_EN), 0);
    EN = 1'b1;
    tick(2);
    pulse_in(1'b1, 1'b0, 1'b0);

    // One-cycle reset mid-RUN
    acps(1);
    trigs(1);
    RST_N = 1'b0;
    tick(1);
    RST_N = 1'b1;
    chk("rst_state",  DW'(STATE), 0);
    chk("rst_sim_en", DW'(SIM_EN), 0);
    chk("rst_az",     AZ_IDX, 0);
    chk("rst_trig",   TRIG_IDX, 0);
    chk("rst_fault",  DW'(FAULT), 0);
    chk("rst_miss",   DW'(MISS_CNT), 0);
    tick(2);
    chk("rst_rearm", DW'(STATE), 2);

    // ARP stops in RUN with ARP_US=20 (limit 30)
    ARP_US = DW'(20);
    ARP = 1'b1;
    tick(3);
    ARP = 1'b0;
    chk("wd_run", DW'(STATE), 3);
`ifdef RADAR_SIM_CTRL_WATCHDOG_EN
    tick(31);
    chk("wd_at_limit", DW'(STATE), 3);
    tick(1);
    chk("wd_fault_state", DW'(STATE), 4);
    chk("wd_fault_bit",   DW'(FAULT), 1);
`else
    tick(200);
    chk("no_wd_state",  DW'(STATE), 3);
    chk("no_wd_sim_en", DW'(SIM_EN), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
